// File: rtl/clfsr_pkg.sv
// rtl/clfsr_pkg.sv - shared seeds, taps, map constant and FSM states for the CLFSR cipher
package clfsr_pkg;

  localparam logic        [15:0] LFSR_SEED_DEF = 16'h0001;
  localparam logic signed [15:0] X_SEED_DEF    = 16'sh7EF0;
  localparam logic signed [15:0] MAP_ONE       = 16'sh7FFF;

  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  typedef enum logic {SHIFT, FULL} state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[TAP_A] ^ v[TAP_B] ^ v[TAP_C] ^ v[TAP_D]};
  endfunction

endpackage

// File: rtl/clfsr_decrypt_if.sv
// rtl/clfsr_decrypt_if.sv - ciphertext-in / plaintext-out handshake bundle
interface clfsr_decrypt_if;

  logic       ct_valid;
  logic       ct_bit;
  logic       ct_ready;
  logic       pt_valid;
  logic [7:0] pt_data;
  logic       pt_ready;

  modport master (
    output ct_valid, ct_bit, pt_ready,
    input  ct_ready, pt_valid, pt_data
  );

  modport slave (
    input  ct_valid, ct_bit, pt_ready,
    output ct_ready, pt_valid, pt_data
  );

endinterface

// File: rtl/clfsr_keystream.sv
// rtl/clfsr_keystream.sv - LFSR xor logistic-map keystream, one step per accepted bit
module clfsr_keystream
  import clfsr_pkg::*;
#(
  parameter logic        [15:0] LFSR_SEED = LFSR_SEED_DEF,
  parameter logic signed [15:0] X_SEED    = X_SEED_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step,
  input  logic load,
  output logic ks_bit
);

  logic        [15:0] lfsr;
  logic signed [15:0] x;
  logic signed [15:0] x_next;
  logic signed [31:0] x_square;
  logic signed [31:0] x_mult;
  logic               unused_mult_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr     <= LFSR_SEED;
      x        <= X_SEED;
      x_square <= '0;
      x_mult   <= '0;
      x_next   <= '0;
    end else if (load) begin
      lfsr     <= LFSR_SEED;
      x        <= X_SEED;
      x_square <= '0;
      x_mult   <= '0;
      x_next   <= '0;
    end else if (step) begin
      // x_next = 1 - 4*x^2 in Q1.15, spread over a three-stage pipeline
      lfsr     <= lfsr_next(lfsr);
      x_square <= 32'(x) * 32'(x);
      x_mult   <= x_square <<< 2;
      x_next   <= MAP_ONE - x_mult[30:15];
      x        <= x_next;
    end
  end

  assign ks_bit           = lfsr[15] ^ x_next[15];
  assign unused_mult_bits = ^{x_mult[31], x_mult[14:0]};

endmodule

// File: rtl/clfsr_decrypt.sv
// rtl/clfsr_decrypt.sv - bit-serial CLFSR decryptor with single-entry byte skid
module clfsr_decrypt
  import clfsr_pkg::*;
#(
  parameter logic        [15:0] LFSR_SEED = LFSR_SEED_DEF,
  parameter logic signed [15:0] X_SEED    = X_SEED_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            resync,
  clfsr_decrypt_if.slave  bus
);

  state_t     state;
  logic [2:0] cnt;
  logic [6:0] shreg;
  logic       ks_bit;
  logic       accept;
  logic       pt_bit;

  // In FULL the held byte can drain and a new bit enter on the same edge
  assign bus.ct_ready = rst_n && ((state == SHIFT) || bus.pt_ready);
  assign accept       = bus.ct_valid && bus.ct_ready && !resync;
  assign pt_bit       = bus.ct_bit ^ ks_bit;

  clfsr_keystream #(
    .LFSR_SEED (LFSR_SEED),
    .X_SEED    (X_SEED)
  ) u_ks (
    .clk    (clk),
    .rst_n  (rst_n),
    .step   (accept),
    .load   (resync),
    .ks_bit (ks_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SHIFT;
      cnt         <= '0;
      shreg       <= '0;
      bus.pt_valid <= 1'b0;
      bus.pt_data  <= 8'h00;
    end else if (resync) begin
      state       <= SHIFT;
      cnt         <= '0;
      shreg       <= '0;
      bus.pt_valid <= 1'b0;
      bus.pt_data  <= 8'h00;
    end else begin
      case (state)
        SHIFT: begin
          if (accept) begin
            shreg <= {shreg[5:0], pt_bit};
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              bus.pt_data  <= {shreg, pt_bit};
              bus.pt_valid <= 1'b1;
              state        <= FULL;
            end
          end
        end
        FULL: begin
          if (bus.pt_ready) begin
            bus.pt_valid <= 1'b0;
            state        <= SHIFT;
            if (accept) begin
              shreg <= {shreg[5:0], pt_bit};
              cnt   <= 3'd1;
            end else begin
              cnt   <= 3'd0;
            end
          end
        end
        default: state <= SHIFT;
      endcase
    end
  end

endmodule

// File: doc/clfsr_decrypt.md
CLFSR_DECRYPT -- requirements
Module: clfsr_decrypt

Interface
REQ-001 Parameter: LFSR_SEED, default 16'h0001, LFSR load value on reset/resync.
REQ-002 Parameter: X_SEED, default 16'sh7EF0 (Q1.15, about 0.9917), chaotic-map state load value on reset/resync.
REQ-003 clk  input  1  single clock; all state is updated on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 resync  input  1  synchronous restart of the keystream and the byte assembler.
REQ-006 ct_valid  input  1  ciphertext bit valid.
REQ-007 ct_bit  input  1  ciphertext bit.
REQ-008 ct_ready  output  1  decryptor can accept a ciphertext bit this cycle.
REQ-009 pt_valid  output  1  plaintext byte valid.
REQ-010 pt_data  output  8  plaintext byte, MSB = first received bit.
REQ-011 pt_ready  input  1  downstream accepts the plaintext byte.

Function
REQ-012 The keystream generator SHALL match the team's CLFSR transmitter bit-exactly, advancing one generator step per accepted ciphertext bit (ct_valid && ct_ready) and holding otherwise.
REQ-013 Generator step, lfsr: next value = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
REQ-014 Generator step, chaotic pipeline: x_square <= x*x (signed 32-bit, Q2.30); x_mult <= x_square <<< 2; x_next <= 16'sh7FFF - x_mult[30:15]; x <= x_next.
REQ-015 The keystream bit used for an accepted ciphertext bit SHALL be lfsr[15] ^ x_next[15], sampled before that step's update.
REQ-016 Plaintext bit = ct_bit ^ keystream bit; it SHALL be shifted into the assembler MSB-first.
REQ-017 FSM state SHIFT (reset state): accept bits while ct_ready=1; bit counter 0..7; on the 8th accepted bit, load pt_data, set pt_valid, go to FULL.
REQ-018 FSM state FULL: ct_ready SHALL equal pt_ready (single-entry skid).
REQ-019 In FULL, if pt_ready=1 and no bit is accepted, go to SHIFT with counter 0.
REQ-020 In FULL, if pt_ready=1 and a bit is accepted in the same cycle, that bit SHALL become bit 7 of the next byte (counter = 1), and the state SHALL go to SHIFT.
REQ-021 In FULL, if pt_ready=0, pt_data and pt_valid SHALL stay stable; the generator SHALL not advance.
REQ-022 In SHIFT, ct_ready SHALL be 1.
REQ-023 Handshake: pt_valid SHALL not drop before pt_ready=1; ct_bit SHALL be ignored when ct_valid=0.
REQ-024 Zero-bubble rate: with pt_ready held at 1, continuous ct_valid SHALL produce one byte per 8 cycles, with no stalls.
REQ-025 resync (registered-cycle effect, priority over everything except rst_n) SHALL:
- reload lfsr=LFSR_SEED, x=X_SEED, and x_square, x_mult, x_next = 0;
- clear the counter, pt_valid and pt_data, and enter SHIFT;
- ignore any ct bit presented in that cycle.
REQ-026 Arithmetic SHALL use two's-complement wrap, with no saturation.

Reset
REQ-027 rst_n=0 SHALL asynchronously force:
- lfsr=LFSR_SEED, x=X_SEED, and x_square, x_mult, x_next = 0;
- state SHIFT, counter 0, pt_valid=0, pt_data=8'h00.
REQ-028 Deassertion SHALL be honoured on the next clock edge; reset mid-byte SHALL discard the partial byte.
REQ-029 While rst_n=0, ct_ready SHALL read 0; after release it SHALL read 1.

Structure
REQ-030 Shared package clfsr_pkg SHALL hold: default seeds, tap positions, the 16'sh7FFF map constant, and the FSM state enum {SHIFT, FULL}.
REQ-031 The keystream generator SHALL be one sub-module, clfsr_keystream (inputs: clk, rst_n, step, load; output: ks_bit), reusable by the transmitter.
REQ-032 The top level SHALL contain only the FSM, the counter, the assembler and the output register.

Verification
REQ-033 Loopback: a transmitter model encrypts 0xA5, 0x3C, 0xFF, 0x00 with the same seeds, and ct_valid is held at 1 with pt_ready=1 -> pt_data sequence is A5, 3C, FF, 00, with pt_valid pulses 8 cycles apart.
REQ-034 Backpressure: pt_ready=0 for 20 cycles after the first byte -> ct_ready=0, pt_data=0xA5 stable, and the generator is frozen; release -> the remaining bytes are correct.
REQ-035 Simultaneous drain and accept: pt_ready=1 in the cycle the next bit arrives -> no bit is lost, and the second byte is still 0x3C.
REQ-036 Gapped input: ct_valid toggled at a random 30% duty -> the plaintext matches loopback exactly.
REQ-037 Resync mid-byte: after 5 bits, assert resync for 1 cycle, and the transmitter model also restarts -> the next byte equals the first encrypted plaintext byte.
REQ-038 Async reset mid-byte: rst_n pulsed low between clock edges -> the outputs clear immediately, and post-reset decode of 0xA5 is correct.
